// File: rtl/updown_pkg.sv
// Shared types and default widths for the triangular sweep sequencer.
// Imported by the interface, the counter and the controller.
package updown_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int HOLD_W_DEF = 4;
    localparam int REP_W_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Control/status bundle of the sweep sequencer.
// master: start/abort/lo/hi/hold/reps out, count/up_down/busy/done/err in.
// slave:  the mirror image, used by the controller.
interface updown_sweep_ctrl_if
    import updown_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int REP_W  = REP_W_DEF
);

    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [HOLD_W-1:0] hold;
    logic [REP_W-1:0]  reps;
    logic [WIDTH-1:0]  count;
    logic              up_down;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, lo, hi, hold, reps,
        input  count, up_down, busy, done, err
    );

    modport slave (
        input  start, abort, lo, hi, hold, reps,
        output count, up_down, busy, done, err
    );

endinterface

// File: rtl/updown_sat.sv
// Saturating up/down counter; load beats en, never wraps.
// Ports: clk, reset (async low), en, up_down, load, load_val, count.
module updown_sat
    import updown_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (up_down) begin
                if (count != MAX) count <= count + 1'b1;
            end else begin
                if (count != '0) count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangular sweep sequencer driving a saturating up/down counter.
// Ports: clk, reset (async low), bus (slave side of the sweep bundle).
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int REP_W  = REP_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_sweep_ctrl_if.slave   bus
);

    sweep_state_t      state;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  hi_q;
    logic [HOLD_W-1:0] hold_q;
    logic [REP_W-1:0]  reps_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic [WIDTH-1:0]  cnt;
    logic              up_down_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              cnt_en;
    logic              cnt_dir;
    logic              cnt_load;
    logic              start_ok;
    logic              last_rep;
    logic              hold_end;

    assign start_ok = (bus.lo < bus.hi) && (bus.reps != '0);
    assign last_rep = (REP_W'(rep_cnt + 1'b1) == reps_q);
    assign hold_end = (hold_cnt == hold_q);

    // Counter steps are decided from the same state/count the FSM sees,
    // so the count register moves in lockstep with the state register.
    always_comb begin
        cnt_en   = 1'b0;
        cnt_dir  = 1'b0;
        cnt_load = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_load = !bus.abort && bus.start && start_ok;
            end
            UP: begin
                if (!bus.abort) begin
                    if (cnt < hi_q) begin
                        cnt_en  = 1'b1;
                        cnt_dir = 1'b1;
                    end else if (hold_q == '0) begin
                        cnt_en  = 1'b1;
                    end
                end
            end
            HOLD_HI: begin
                cnt_en = !bus.abort && hold_end;
            end
            DOWN: begin
                if (!bus.abort) begin
                    if (cnt > lo_q) begin
                        cnt_en  = 1'b1;
                    end else if (!last_rep && hold_q == '0) begin
                        cnt_en  = 1'b1;
                        cnt_dir = 1'b1;
                    end
                end
            end
            HOLD_LO: begin
                if (!bus.abort && hold_end) begin
                    cnt_en  = 1'b1;
                    cnt_dir = 1'b1;
                end
            end
            default: ;
        endcase
    end

    updown_sat #(.WIDTH(WIDTH)) u_sat (
        .clk      (clk),
        .reset    (reset),
        .en       (cnt_en),
        .up_down  (cnt_dir),
        .load     (cnt_load),
        .load_val (bus.lo),
        .count    (cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            hold_q    <= '0;
            reps_q    <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            up_down_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.abort && busy_q) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!bus.abort && bus.start) begin
                            if (start_ok) begin
                                lo_q      <= bus.lo;
                                hi_q      <= bus.hi;
                                hold_q    <= bus.hold;
                                reps_q    <= bus.reps;
                                rep_cnt   <= '0;
                                hold_cnt  <= '0;
                                state     <= UP;
                                busy_q    <= 1'b1;
                                up_down_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    UP: begin
                        if (cnt >= hi_q) begin
                            if (hold_q != '0) begin
                                state    <= HOLD_HI;
                                hold_cnt <= HOLD_W'(1);
                            end else begin
                                state     <= DOWN;
                                up_down_q <= 1'b0;
                            end
                        end
                    end
                    HOLD_HI: begin
                        if (hold_end) begin
                            state     <= DOWN;
                            up_down_q <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    DOWN: begin
                        if (cnt <= lo_q) begin
                            rep_cnt <= rep_cnt + 1'b1;
                            if (last_rep) begin
                                state  <= DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else if (hold_q != '0) begin
                                state    <= HOLD_LO;
                                hold_cnt <= HOLD_W'(1);
                            end else begin
                                state     <= UP;
                                up_down_q <= 1'b1;
                            end
                        end
                    end
                    HOLD_LO: begin
                        if (hold_end) begin
                            state     <= UP;
                            up_down_q <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count   = cnt;
    assign bus.up_down = up_down_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl: sweeps, dwell, full range,
// rejected starts, busy-time start, abort and mid-sweep reset.
module tb_updown_sweep_ctrl;

    localparam int WIDTH  = 4;
    localparam int HOLD_W = 4;
    localparam int REP_W  = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    updown_sweep_ctrl_if #(
        .WIDTH  (WIDTH),
        .HOLD_W (HOLD_W),
        .REP_W  (REP_W)
    ) bus_if ();

    updown_sweep_ctrl #(
        .WIDTH  (WIDTH),
        .HOLD_W (HOLD_W),
        .REP_W  (REP_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int lo, input int hi, input int hold,
                      input int reps);
        bus_if.lo    = 4'(lo);
        bus_if.hi    = 4'(hi);
        bus_if.hold  = 4'(hold);
        bus_if.reps  = 4'(reps);
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus_if.count !== 4'd0 || bus_if.busy !== 1'b0 ||
            bus_if.up_down !== 1'b0 || bus_if.done !== 1'b0 ||
            bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d busy=%b ud=%b done=%b err=%b, want all 0",
                     bus_if.count, bus_if.busy, bus_if.up_down,
                     bus_if.done, bus_if.err);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus_if.count !== 4'd0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: count=%0d busy=%b, want 0 0",
                     bus_if.count, bus_if.busy);
        end
    endtask

    task automatic test_basic();
        int ec[7];
        bit eu[7];
        ec = '{2, 3, 4, 5, 4, 3, 2};
        eu = '{1, 1, 1, 1, 0, 0, 0};
        go(2, 5, 0, 1);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus_if.busy !== 1'b1 || bus_if.count !== 4'(ec[i]) ||
                bus_if.up_down !== eu[i] || bus_if.done !== 1'b0) begin
                errors++;
                $display("FAIL basic[%0d]: busy=%b count=%0d ud=%b done=%b, want 1 %0d %b 0",
                         i, bus_if.busy, bus_if.count, bus_if.up_down,
                         bus_if.done, ec[i], eu[i]);
            end
            tick();
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 ||
            bus_if.count !== 4'd2) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b count=%0d, want 1 0 2",
                     bus_if.done, bus_if.busy, bus_if.count);
        end
        tick();
        checks++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 ||
            bus_if.count !== 4'd2 || bus_if.up_down !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: done=%b busy=%b count=%0d ud=%b, want 0 0 2 0",
                     bus_if.done, bus_if.busy, bus_if.count, bus_if.up_down);
        end
    endtask

    task automatic test_hold();
        int ec[16];
        bit eu[16];
        ec = '{2, 3, 4, 5, 5, 4, 3, 2, 2, 3, 4, 5, 5, 4, 3, 2};
        eu = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        go(2, 5, 1, 2);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus_if.busy !== 1'b1 || bus_if.count !== 4'(ec[i]) ||
                bus_if.up_down !== eu[i]) begin
                errors++;
                $display("FAIL hold[%0d]: busy=%b count=%0d ud=%b, want 1 %0d %b",
                         i, bus_if.busy, bus_if.count, bus_if.up_down,
                         ec[i], eu[i]);
            end
            tick();
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 ||
            bus_if.count !== 4'd2) begin
            errors++;
            $display("FAIL hold_done: done=%b busy=%b count=%0d, want 1 0 2",
                     bus_if.done, bus_if.busy, bus_if.count);
        end
        tick();
    endtask

    task automatic test_full_range();
        int exp_c;
        bit exp_u;
        go(0, 15, 0, 1);
        for (int i = 0; i < 31; i++) begin
            exp_c = (i <= 15) ? i : 30 - i;
            exp_u = (i <= 15);
            checks++;
            if (bus_if.busy !== 1'b1 || bus_if.count !== 4'(exp_c) ||
                bus_if.up_down !== exp_u) begin
                errors++;
                $display("FAIL full[%0d]: busy=%b count=%0d ud=%b, want 1 %0d %b",
                         i, bus_if.busy, bus_if.count, bus_if.up_down,
                         exp_c, exp_u);
            end
            tick();
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.count !== 4'd0) begin
            errors++;
            $display("FAIL full_done: done=%b count=%0d, want 1 0",
                     bus_if.done, bus_if.count);
        end
        tick();
    endtask

    task automatic test_reject();
        go(5, 5, 0, 1);
        checks++;
        if (bus_if.err !== 1'b1 || bus_if.busy !== 1'b0 ||
            bus_if.count !== 4'd0) begin
            errors++;
            $display("FAIL reject_eq: err=%b busy=%b count=%0d, want 1 0 0",
                     bus_if.err, bus_if.busy, bus_if.count);
        end
        tick();
        checks++;
        if (bus_if.err !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_eq_after: err=%b busy=%b, want 0 0",
                     bus_if.err, bus_if.busy);
        end
        go(2, 5, 0, 0);
        checks++;
        if (bus_if.err !== 1'b1 || bus_if.busy !== 1'b0 ||
            bus_if.count !== 4'd0) begin
            errors++;
            $display("FAIL reject_reps: err=%b busy=%b count=%0d, want 1 0 0",
                     bus_if.err, bus_if.busy, bus_if.count);
        end
        tick();
    endtask

    task automatic test_busy_start();
        int ec[7];
        ec = '{2, 3, 4, 5, 4, 3, 2};
        go(2, 5, 0, 1);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus_if.busy !== 1'b1 || bus_if.count !== 4'(ec[i]) ||
                bus_if.err !== 1'b0) begin
                errors++;
                $display("FAIL busy_start[%0d]: busy=%b count=%0d err=%b, want 1 %0d 0",
                         i, bus_if.busy, bus_if.count, bus_if.err, ec[i]);
            end
            if (i == 1) begin
                bus_if.lo    = 4'd0;
                bus_if.hi    = 4'd15;
                bus_if.reps  = 4'd3;
                bus_if.start = 1'b1;
            end
            tick();
            bus_if.start = 1'b0;
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.count !== 4'd2) begin
            errors++;
            $display("FAIL busy_start_done: done=%b count=%0d, want 1 2",
                     bus_if.done, bus_if.count);
        end
        tick();
    endtask

    task automatic test_abort();
        go(2, 5, 1, 2);
        tick();
        tick();
        checks++;
        if (bus_if.count !== 4'd4 || bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: count=%0d busy=%b, want 4 1",
                     bus_if.count, bus_if.busy);
        end
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.count !== 4'd4 ||
            bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b count=%0d done=%b err=%b, want 0 4 0 0",
                     bus_if.busy, bus_if.count, bus_if.done, bus_if.err);
        end
        tick();
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.count !== 4'd4 ||
            bus_if.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: busy=%b count=%0d done=%b, want 0 4 0",
                     bus_if.busy, bus_if.count, bus_if.done);
        end
        bus_if.abort = 1'b1;
        go(1, 6, 0, 1);
        bus_if.abort = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.err !== 1'b0 ||
            bus_if.count !== 4'd4) begin
            errors++;
            $display("FAIL abort_start: busy=%b err=%b count=%0d, want 0 0 4",
                     bus_if.busy, bus_if.err, bus_if.count);
        end
        tick();
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_after: busy=%b err=%b, want 0 0",
                     bus_if.busy, bus_if.err);
        end
    endtask

    task automatic test_reset_mid();
        go(2, 5, 0, 1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus_if.count !== 4'd0 || bus_if.busy !== 1'b0 ||
            bus_if.up_down !== 1'b0 || bus_if.done !== 1'b0 ||
            bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: count=%0d busy=%b ud=%b done=%b err=%b, want all 0",
                     bus_if.count, bus_if.busy, bus_if.up_down,
                     bus_if.done, bus_if.err);
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_if.count !== 4'd0 || bus_if.busy !== 1'b0 ||
            bus_if.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: count=%0d busy=%b done=%b, want 0 0 0",
                     bus_if.count, bus_if.busy, bus_if.done);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        bus_if.lo    = '0;
        bus_if.hi    = '0;
        bus_if.hold  = '0;
        bus_if.reps  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_hold();
        test_full_range();
        test_reject();
        test_busy_start();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencer that drives a saturating up/down counter through a programmed triangular sweep. Each sweep runs lo → hi, dwells, runs hi → lo, dwells, and repeats for a programmed number of passes. It has a start/busy/done handshake and supports abort. It sits in front of the counter datapath and owns its `up_down` and load controls, so no other block steps the counter during a sweep.

## Interface
- `WIDTH`, 4, counter width
- `HOLD_W`, 4, width of dwell-length field
- `REP_W`, 4, width of repetition-count field

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  sample parameters and begin sweep (IDLE only)
- `abort`  in  1  terminate sweep, return to IDLE
- `lo`  in  WIDTH  sweep lower bound
- `hi`  in  WIDTH  sweep upper bound
- `hold`  in  HOLD_W  extra dwell cycles at each endpoint
- `reps`  in  REP_W  number of up+down passes
- `count`  out  WIDTH  counter value
- `up_down`  out  1  current direction: 1 = up, 0 = down
- `busy`  out  1  high in UP, HOLD_HI, DOWN, HOLD_LO
- `done`  out  1  one-cycle pulse after normal completion
- `err`  out  1  one-cycle pulse when `start` is rejected

## Operation
- States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO, DONE.
- **IDLE:**
  - `start` with `lo < hi` and `reps != 0`: latch lo/hi/hold/reps, `count <= lo`, clear rep_cnt, go to UP.
  - `start` otherwise: pulse `err`, stay in IDLE, `count` unchanged.
- **UP:**
  - `count < hi`: `count + 1`.
  - `count == hi`: if hold > 0, go to HOLD_HI with hold_cnt = 1; else `count - 1` and go to DOWN.
- **HOLD_HI:** if hold_cnt == hold, `count - 1` and go to DOWN; else hold_cnt + 1.
- **DOWN:**
  - `count > lo`: `count - 1`.
  - `count == lo`: rep_cnt + 1.
    - Last rep: go to DONE, count held.
    - Otherwise, hold > 0: go to HOLD_LO with hold_cnt = 1.
    - Otherwise: `count + 1` and go to UP.
- **HOLD_LO:** if hold_cnt == hold, `count + 1` and go to UP; else hold_cnt + 1.
- **DONE:** `done` = 1 for one cycle, then IDLE. `count` stays at lo.
- **Dwell:** each endpoint is visible for exactly hold+1 cycles. No dwell at lo before the first pass or after the last.
- **up_down:** 1 in UP and HOLD_HI, 0 in DOWN and HOLD_LO, holds its last value in IDLE and DONE.
- **abort:**
  - In any busy state: go to IDLE on the next edge; `count` freezes at its current value; no `done`, no `err`.
  - In IDLE: `abort` has priority over `start`. Start is ignored, no `err`.
- **Busy-time inputs:** `start` is ignored while busy. Parameter inputs are don't-care except on the accepted start cycle.
- **Counter:** never wraps; it saturates at 0 and 2^WIDTH−1. Unreachable when `lo < hi`, but required in the sub-module.

## Timing
- Reset state: IDLE, `count` = 0, `up_down` = 0, `busy` = 0, `done` = 0, `err` = 0, internal counters = 0.
- Reset mid-sweep: immediate return to the reset values; no `done`.
- All outputs are registered and change only on rising `clk` or on reset assertion.
- The cycle after an accepted start: `busy` = 1, `count` = lo.
- Busy duration: 2·(hi−lo)·reps + 1 + (2·reps−1)·hold cycles. DONE follows, then IDLE.
- `err` is asserted the cycle after the rejected start.

## Structure
- Package `updown_pkg`:
  - state enum `sweep_state_t`: IDLE, UP, HOLD_HI, DOWN, HOLD_LO, DONE
  - default width constants
- Sub-module `updown_sat`: saturating WIDTH-bit up/down counter.
  - Ports: `clk`, `reset`, `en`, `up_down`, `load`, `load_val`, `count`.
  - `load` has priority over `en`.
- The controller holds the FSM, hold_cnt, rep_cnt and latched parameters; it drives `updown_sat` and forwards `count`.

## Test plan
- Reset: assert `reset`=0 mid-sweep → all outputs 0 immediately; after release, IDLE with `count` = 0.
- lo=2, hi=5, hold=0, reps=1, `start` pulse → `count` 2,3,4,5,4,3,2 over 7 busy cycles, `done` pulse with `count` = 2, `up_down` 1 then 0.
- lo=2, hi=5, hold=1, reps=2 → `count` 2,3,4,5,5,4,3,2,2,3,4,5,5,4,3,2 (16 busy cycles), then `done`.
- lo=0, hi=15, hold=0, reps=1 → full-range sweep with no wrap: 15 follows 14, then 14 follows 15; ends at 0 after 31 cycles.
- Rejected starts: lo=5, hi=5 → `err` pulse, `busy` stays 0. reps=0 → `err`. `start` while busy → ignored.
- `abort` in cycle 3 of the lo=2, hi=5, hold=1, reps=2 sweep → IDLE next cycle, `count` frozen at 4, no `done`. `start` together with `abort` in IDLE → no sweep, no `err`.
